// File: rtl/instruction_execute.sv
// RV32I execute stage: ALU, branch/jump resolution, fetch redirect and EX/MEM register.
// Squashes the two wrong-path instructions that follow a redirect, since upstream has no flush.
module instruction_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_EX_A,
    input  logic [31:0] ID_EX_B,
    input  logic [31:0] ID_EX_IMM,
    input  logic [31:0] ID_EX_PC,
    input  logic [4:0]  ID_EX_RD,
    input  logic [2:0]  alucontrol,
    input  logic [6:0]  alucontrol7,
    input  logic [1:0]  alu_type_sel,
    input  logic        b_imm_sel,
    input  logic        branch,
    input  logic        jump,
    input  logic        memwrite_en,
    input  logic        regwrite_en,
    input  logic        wb_sel,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic [31:0] EX_MEM_ALU,
    output logic [31:0] EX_MEM_WD,
    output logic [4:0]  EX_MEM_RD,
    output logic [2:0]  EX_MEM_funct3,
    output logic        EX_MEM_regwrite,
    output logic        EX_MEM_memwrite,
    output logic        EX_MEM_wb_sel,
    output logic        EX_MEM_valid
);

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT3 = 2'b10,
        ALU_UPPER  = 2'b11
    } alu_type_e;

    logic [1:0]  r_squash;
    logic        w_live;
    logic [31:0] w_opb;
    logic [4:0]  w_shamt;
    logic [31:0] w_sra;
    logic        w_lt_s;
    logic        w_lt_u;
    logic        w_br_lt_s;
    logic        w_br_lt_u;
    logic        w_taken;
    logic [31:0] w_alu;
    logic [31:0] w_result;
    logic [31:0] w_jalr_sum;

    assign w_live  = (r_squash == 2'd0);
    assign w_opb   = b_imm_sel ? ID_EX_IMM : ID_EX_B;
    assign w_shamt = w_opb[4:0];
    // Kept separate so the arithmetic shift is not demoted to logical by an unsigned context.
    assign w_sra     = $signed(ID_EX_A) >>> w_shamt;
    assign w_lt_s    = $signed(ID_EX_A) < $signed(w_opb);
    assign w_lt_u    = ID_EX_A < w_opb;
    assign w_br_lt_s = $signed(ID_EX_A) < $signed(ID_EX_B);
    assign w_br_lt_u = ID_EX_A < ID_EX_B;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_taken = 1'b0;
        case (alucontrol)
            3'b000:  w_taken = (ID_EX_A == ID_EX_B);
            3'b001:  w_taken = (ID_EX_A != ID_EX_B);
            3'b100:  w_taken = w_br_lt_s;
            3'b101:  w_taken = !w_br_lt_s;
            3'b110:  w_taken = w_br_lt_u;
            3'b111:  w_taken = !w_br_lt_u;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = 32'd0;
        case (alu_type_sel)
            ALU_ADD:    w_alu = ID_EX_A + w_opb;
            ALU_BRANCH: w_alu = 32'd0;
            ALU_FUNCT3: begin
                case (alucontrol)
                    3'b000:  w_alu = (alucontrol7[5] && !b_imm_sel) ? ID_EX_A - w_opb : ID_EX_A + w_opb;
                    3'b001:  w_alu = ID_EX_A << w_shamt;
                    3'b010:  w_alu = {31'd0, w_lt_s};
                    3'b011:  w_alu = {31'd0, w_lt_u};
                    3'b100:  w_alu = ID_EX_A ^ w_opb;
                    3'b101:  w_alu = alucontrol7[5] ? w_sra : (ID_EX_A >> w_shamt);
                    3'b110:  w_alu = ID_EX_A | w_opb;
                    default: w_alu = ID_EX_A & w_opb;
                endcase
            end
            default:    w_alu = b_imm_sel ? ID_EX_IMM : ID_EX_PC + ID_EX_IMM;
        endcase
    end

    assign w_result   = jump ? ID_EX_PC + 32'd4 : w_alu;
    assign w_jalr_sum = ID_EX_A + ID_EX_IMM;
    assign PCTargetE  = (jump && b_imm_sel) ? {w_jalr_sum[31:1], 1'b0} : ID_EX_PC + ID_EX_IMM;
    assign PCSrcE     = !rst && w_live && (jump || (branch && w_taken));

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_squash <= 2'd0;
        end else if (PCSrcE) begin
            r_squash <= 2'd2;
        end else if (r_squash != 2'd0) begin
            r_squash <= r_squash - 2'd1;
        end
    end

    // Data fields latch even when squashed; only the commit controls are gated by liveness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EX_MEM_ALU      <= 32'd0;
            EX_MEM_WD       <= 32'd0;
            EX_MEM_RD       <= 5'd0;
            EX_MEM_funct3   <= 3'd0;
            EX_MEM_regwrite <= 1'b0;
            EX_MEM_memwrite <= 1'b0;
            EX_MEM_wb_sel   <= 1'b0;
            EX_MEM_valid    <= 1'b0;
        end else begin
            EX_MEM_ALU      <= w_result;
            EX_MEM_WD       <= ID_EX_B;
            EX_MEM_RD       <= ID_EX_RD;
            EX_MEM_funct3   <= alucontrol;
            EX_MEM_regwrite <= regwrite_en && w_live;
            EX_MEM_memwrite <= memwrite_en && w_live;
            EX_MEM_wb_sel   <= wb_sel;
            EX_MEM_valid    <= w_live;
        end
    end

endmodule

// File: tb/tb_instruction_execute.sv
// Directed self-checking bench for instruction_execute: ALU ops, branches, jumps,
// squash window after a redirect, and asynchronous reset in the middle of a squash.
module tb_instruction_execute;

    logic        clk;
    logic        rst;
    logic [31:0] ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_PC;
    logic [4:0]  ID_EX_RD;
    logic [2:0]  alucontrol;
    logic [6:0]  alucontrol7;
    logic [1:0]  alu_type_sel;
    logic        b_imm_sel, branch, jump, memwrite_en, regwrite_en, wb_sel;
    logic        PCSrcE;
    logic [31:0] PCTargetE, EX_MEM_ALU, EX_MEM_WD;
    logic [4:0]  EX_MEM_RD;
    logic [2:0]  EX_MEM_funct3;
    logic        EX_MEM_regwrite, EX_MEM_memwrite, EX_MEM_wb_sel, EX_MEM_valid;

    int n_cmp;
    int n_err;

    instruction_execute dut (
        .clk(clk), .rst(rst),
        .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_IMM(ID_EX_IMM), .ID_EX_PC(ID_EX_PC),
        .ID_EX_RD(ID_EX_RD), .alucontrol(alucontrol), .alucontrol7(alucontrol7),
        .alu_type_sel(alu_type_sel), .b_imm_sel(b_imm_sel), .branch(branch), .jump(jump),
        .memwrite_en(memwrite_en), .regwrite_en(regwrite_en), .wb_sel(wb_sel),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .EX_MEM_ALU(EX_MEM_ALU), .EX_MEM_WD(EX_MEM_WD),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_funct3(EX_MEM_funct3), .EX_MEM_regwrite(EX_MEM_regwrite),
        .EX_MEM_memwrite(EX_MEM_memwrite), .EX_MEM_wb_sel(EX_MEM_wb_sel), .EX_MEM_valid(EX_MEM_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Plain ALU instruction (type 10) with regwrite; other controls cleared.
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic bsel, input logic [2:0] f3, input logic [6:0] f7);
        ID_EX_A = a; ID_EX_B = b; ID_EX_IMM = imm; ID_EX_PC = 32'h0; ID_EX_RD = 5'd5;
        alucontrol = f3; alucontrol7 = f7; alu_type_sel = 2'b10; b_imm_sel = bsel;
        branch = 1'b0; jump = 1'b0; memwrite_en = 1'b0; regwrite_en = 1'b1; wb_sel = 1'b0;
    endtask

    task automatic jal(input logic [31:0] pc, input logic [31:0] imm);
        op(32'h0, 32'h0, imm, 1'b0, 3'b000, 7'h0);
        ID_EX_PC = pc; ID_EX_RD = 5'd1; alu_type_sel = 2'b00; jump = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        jal(32'h80, 32'h100);
        #3;
        check("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
        step();
        check("rst_alu", EX_MEM_ALU, 32'd0);
        check("rst_valid", {31'd0, EX_MEM_valid}, 32'd0);
        check("rst_regwrite", {31'd0, EX_MEM_regwrite}, 32'd0);
        #2 rst = 1'b0;

        // ALU sweep
        op(32'hFFFF_FFF0, 32'h10, 32'h0, 1'b0, 3'b000, 7'h00); step();
        check("add_wrap", EX_MEM_ALU, 32'h0000_0000);
        check("add_valid", {31'd0, EX_MEM_valid}, 32'd1);
        check("add_regwrite", {31'd0, EX_MEM_regwrite}, 32'd1);
        check("add_rd", {27'd0, EX_MEM_RD}, 32'd5);
        op(32'hFFFF_FFF0, 32'h10, 32'h0, 1'b0, 3'b000, 7'h20); step();
        check("sub", EX_MEM_ALU, 32'hFFFF_FFE0);
        op(32'hFFFF_FFF0, 32'h10, 32'h20, 1'b1, 3'b000, 7'h20); step();
        check("addi_f7_ignored", EX_MEM_ALU, 32'h0000_0010);
        op(32'hFFFF_FFF0, 32'h10, 32'h4, 1'b1, 3'b101, 7'h20); step();
        check("sra", EX_MEM_ALU, 32'hFFFF_FFFF);
        op(32'hFFFF_FFF0, 32'h10, 32'h4, 1'b1, 3'b101, 7'h00); step();
        check("srl", EX_MEM_ALU, 32'h0FFF_FFFF);
        op(32'h0000_0003, 32'h24, 32'h0, 1'b0, 3'b001, 7'h00); step();
        check("sll_shamt5", EX_MEM_ALU, 32'h0000_0030);
        op(32'hFFFF_FFF0, 32'h10, 32'h0, 1'b0, 3'b010, 7'h00); step();
        check("slt", EX_MEM_ALU, 32'd1);
        op(32'hFFFF_FFF0, 32'h10, 32'h0, 1'b0, 3'b011, 7'h00); step();
        check("sltu", EX_MEM_ALU, 32'd0);
        op(32'hF0F0_0000, 32'h0FF0_0000, 32'h0, 1'b0, 3'b100, 7'h00); step();
        check("xor", EX_MEM_ALU, 32'hFF00_0000);

        // LUI / AUIPC
        op(32'h5, 32'h0, 32'h1234_5000, 1'b1, 3'b000, 7'h00);
        alu_type_sel = 2'b11; step();
        check("lui", EX_MEM_ALU, 32'h1234_5000);
        op(32'h5, 32'h0, 32'h1234_5000, 1'b0, 3'b000, 7'h00);
        alu_type_sel = 2'b11; ID_EX_PC = 32'h100; step();
        check("auipc", EX_MEM_ALU, 32'h1234_5100);

        // Store (SW)
        op(32'h1000, 32'hDEAD_BEEF, 32'h8, 1'b1, 3'b010, 7'h00);
        alu_type_sel = 2'b00; regwrite_en = 1'b0; memwrite_en = 1'b1; step();
        check("st_addr", EX_MEM_ALU, 32'h1008);
        check("st_wd", EX_MEM_WD, 32'hDEAD_BEEF);
        check("st_memwrite", {31'd0, EX_MEM_memwrite}, 32'd1);
        check("st_funct3", {29'd0, EX_MEM_funct3}, 32'd2);

        // BGEU not taken: 1 >= 0xFFFFFFFF unsigned is false
        op(32'h1, 32'hFFFF_FFFF, 32'h40, 1'b0, 3'b111, 7'h00);
        alu_type_sel = 2'b01; branch = 1'b1; regwrite_en = 1'b0; ID_EX_PC = 32'h200;
        #1 check("bgeu_pcsrc", {31'd0, PCSrcE}, 32'd0);
        step();
        check("bgeu_result0", EX_MEM_ALU, 32'd0);
        op(32'h1, 32'h2, 32'h0, 1'b0, 3'b000, 7'h00); step();
        check("bgeu_no_squash", {31'd0, EX_MEM_valid}, 32'd1);

        // BLT taken: -1 < 1 signed
        op(32'hFFFF_FFFF, 32'h1, 32'h20, 1'b0, 3'b100, 7'h00);
        alu_type_sel = 2'b01; branch = 1'b1; regwrite_en = 1'b0; ID_EX_PC = 32'h100;
        #1 check("blt_pcsrc", {31'd0, PCSrcE}, 32'd1);
        check("blt_target", PCTargetE, 32'h120);
        step();
        check("blt_commits", {31'd0, EX_MEM_valid}, 32'd1);
        op(32'h7, 32'h1, 32'h0, 1'b0, 3'b000, 7'h00); memwrite_en = 1'b1; step();
        check("sq1_valid", {31'd0, EX_MEM_valid}, 32'd0);
        check("sq1_regwrite", {31'd0, EX_MEM_regwrite}, 32'd0);
        check("sq1_memwrite", {31'd0, EX_MEM_memwrite}, 32'd0);
        check("sq1_data", EX_MEM_ALU, 32'h8);
        step();
        check("sq2_valid", {31'd0, EX_MEM_valid}, 32'd0);
        check("sq2_regwrite", {31'd0, EX_MEM_regwrite}, 32'd0);
        step();
        check("n3_valid", {31'd0, EX_MEM_valid}, 32'd1);
        check("n3_memwrite", {31'd0, EX_MEM_memwrite}, 32'd1);

        // JALR, then a JAL in the squash window that must not redirect or reload
        op(32'h203, 32'h0, 32'h4, 1'b1, 3'b000, 7'h00);
        alu_type_sel = 2'b00; jump = 1'b1; ID_EX_PC = 32'h40; ID_EX_RD = 5'd1;
        #1 check("jalr_pcsrc", {31'd0, PCSrcE}, 32'd1);
        check("jalr_target", PCTargetE, 32'h206);
        step();
        check("jalr_link", EX_MEM_ALU, 32'h44);
        check("jalr_regwrite", {31'd0, EX_MEM_regwrite}, 32'd1);
        check("jalr_rd", {27'd0, EX_MEM_RD}, 32'd1);
        jal(32'h80, 32'h100);
        #1 check("sqjal_pcsrc", {31'd0, PCSrcE}, 32'd0);
        step();
        check("sqjal_valid", {31'd0, EX_MEM_valid}, 32'd0);
        op(32'h1, 32'h1, 32'h0, 1'b0, 3'b000, 7'h00); step();
        check("sqjal_n2_valid", {31'd0, EX_MEM_valid}, 32'd0);
        step();
        check("sqjal_n3_valid", {31'd0, EX_MEM_valid}, 32'd1);

        // JAL commits PC+4, then reset mid-squash
        jal(32'h300, 32'h40);
        #1 check("jal_target", PCTargetE, 32'h340);
        step();
        check("jal_link", EX_MEM_ALU, 32'h304);
        check("jal_valid", {31'd0, EX_MEM_valid}, 32'd1);
        jal(32'h500, 32'h10);
        #2 rst = 1'b1;
        #1;
        check("midrst_alu", EX_MEM_ALU, 32'd0);
        check("midrst_rd", {27'd0, EX_MEM_RD}, 32'd0);
        check("midrst_pcsrc", {31'd0, PCSrcE}, 32'd0);
        step();
        rst = 1'b0;
        op(32'h2, 32'h3, 32'h0, 1'b0, 3'b111, 7'h00); step();
        check("postrst_valid", {31'd0, EX_MEM_valid}, 32'd1);
        check("postrst_and", EX_MEM_ALU, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
